// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port,
// optional write-to-read bypass and a bulk-clear sequencer.
// Optional macro REGFILE_R0_ZERO_EN hardwires register 0 to zero.
`timescale 1ns/1ps

module regfile_param #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int BYPASS     = 1,
  localparam int SEL_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_WIDTH-1:0]  aReg_select,
  input  logic [SEL_WIDTH-1:0]  bReg_select,
  input  logic                  load_enable,
  input  logic [SEL_WIDTH-1:0]  dest_select,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [DATA_WIDTH-1:0] operandA,
  output logic [DATA_WIDTH-1:0] operandB
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [SEL_WIDTH-1:0]  clr_ptr;
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  logic dest_ok;
  logic wr_en;
  logic clr_last;
  logic a_ok;
  logic b_ok;

  // Index 0 is never a legal write target when register 0 is hardwired.
`ifdef REGFILE_R0_ZERO_EN
  assign dest_ok = (32'(dest_select) < NUM_REGS) && (dest_select != '0);
`else
  assign dest_ok = (32'(dest_select) < NUM_REGS);
`endif

  assign wr_en    = load_enable && dest_ok && (state != CLEAR);
  assign clr_last = (clr_ptr == SEL_WIDTH'(NUM_REGS - 1));
  assign a_ok     = (32'(aReg_select) < NUM_REGS);
  assign b_ok     = (32'(bReg_select) < NUM_REGS);

  assign clear_busy = (state == CLEAR);
  assign clear_done = (state == DONE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (clear_req) state_next = CLEAR;
      CLEAR:   if (clr_last)  state_next = DONE;
      DONE:    state_next = clear_req ? CLEAR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The pointer only advances inside CLEAR, so every new sequence starts at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      clr_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR && !clr_last) begin
        clr_ptr <= clr_ptr + SEL_WIDTH'(1);
      end else begin
        clr_ptr <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      mem[dest_select] <= reg_data;
    end
  end

  // wr_en already excludes CLEAR and illegal destinations, so forwarding follows it.
  always_comb begin
    operandA = '0;
    if (a_ok) operandA = mem[aReg_select];
    if (BYPASS != 0 && wr_en && dest_select == aReg_select) operandA = reg_data;
`ifdef REGFILE_R0_ZERO_EN
    if (aReg_select == '0) operandA = '0;
`endif
  end

  always_comb begin
    operandB = '0;
    if (b_ok) operandB = mem[bReg_select];
    if (BYPASS != 0 && wr_en && dest_select == bReg_select) operandB = reg_data;
`ifdef REGFILE_R0_ZERO_EN
    if (bReg_select == '0) operandB = '0;
`endif
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: one bypassing and one non-bypassing
// instance share the same stimulus; a negedge monitor checks queued expectations.
`timescale 1ns/1ps

module tb_regfile_param;

  logic       clk;
  logic       reset;
  logic [1:0] a_sel;
  logic [1:0] b_sel;
  logic       load_enable;
  logic [1:0] dest_select;
  logic [7:0] reg_data;
  logic       clear_req;

  logic       busy_byp, done_byp, busy_nob, done_nob;
  logic [7:0] op_a_byp, op_b_byp, op_a_nob, op_b_nob;

`ifdef REGFILE_R0_ZERO_EN
  localparam logic [7:0] R0_11 = 8'h00;
  localparam logic [7:0] R0_5A = 8'h00;
`else
  localparam logic [7:0] R0_11 = 8'h11;
  localparam logic [7:0] R0_5A = 8'h5A;
`endif

  typedef struct {
    string      name;
    logic [7:0] a_byp;
    logic [7:0] b_byp;
    logic [7:0] a_nob;
    logic [7:0] b_nob;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  regfile_param #(.DATA_WIDTH(8), .NUM_REGS(4), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset),
    .aReg_select(a_sel), .bReg_select(b_sel),
    .load_enable(load_enable), .dest_select(dest_select), .reg_data(reg_data),
    .clear_req(clear_req), .clear_busy(busy_byp), .clear_done(done_byp),
    .operandA(op_a_byp), .operandB(op_b_byp)
  );

  regfile_param #(.DATA_WIDTH(8), .NUM_REGS(4), .BYPASS(0)) dut_nob (
    .clk(clk), .reset(reset),
    .aReg_select(a_sel), .bReg_select(b_sel),
    .load_enable(load_enable), .dest_select(dest_select), .reg_data(reg_data),
    .clear_req(clear_req), .clear_busy(busy_nob), .clear_done(done_nob),
    .operandA(op_a_nob), .operandB(op_b_nob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string what, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", what, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp({e.name, ".byp.A"}, op_a_byp, e.a_byp);
    cmp({e.name, ".byp.B"}, op_b_byp, e.b_byp);
    cmp({e.name, ".nob.A"}, op_a_nob, e.a_nob);
    cmp({e.name, ".nob.B"}, op_b_nob, e.b_nob);
    cmp({e.name, ".byp.busy"}, {7'd0, busy_byp}, {7'd0, e.busy});
    cmp({e.name, ".byp.done"}, {7'd0, done_byp}, {7'd0, e.done});
    cmp({e.name, ".nob.busy"}, {7'd0, busy_nob}, {7'd0, e.busy});
    cmp({e.name, ".nob.done"}, {7'd0, done_nob}, {7'd0, e.done});
  endtask

  // Outputs are combinational; the monitor samples them mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  task automatic applyStimulus(
    input string name, input logic rst, input logic le, input logic [1:0] dest,
    input logic [7:0] data, input logic clr, input logic [1:0] a, input logic [1:0] b,
    input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ea0, input logic [7:0] eb0,
    input logic ebusy, input logic edone);
    exp_t e;
    reset       = rst;
    load_enable = le;
    dest_select = dest;
    reg_data    = data;
    clear_req   = clr;
    a_sel       = a;
    b_sel       = b;
    e.name  = name;
    e.a_byp = ea;
    e.b_byp = eb;
    e.a_nob = ea0;
    e.b_nob = eb0;
    e.busy  = ebusy;
    e.done  = edone;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; load_enable = 1'b0; dest_select = '0; reg_data = '0;
    clear_req = 1'b0; a_sel = '0; b_sel = '0;
    repeat (2) @(posedge clk);
    #1;

    //            name          rst le dest data   clr a  b   eA     eB     eA0    eB0    bsy dn
    applyStimulus("wr_r0",      1, 1, 0, 8'h11, 0, 0, 0, R0_11, R0_11, 8'h00, 8'h00, 0, 0);
    applyStimulus("wr_r1",      1, 1, 1, 8'h22, 0, 0, 1, R0_11, 8'h22, R0_11, 8'h00, 0, 0);
    applyStimulus("wr_r2",      1, 1, 2, 8'h33, 0, 1, 2, 8'h22, 8'h33, 8'h22, 8'h00, 0, 0);
    applyStimulus("wr_r3",      1, 1, 3, 8'h44, 0, 2, 3, 8'h33, 8'h44, 8'h33, 8'h00, 0, 0);
    applyStimulus("rst_mid",    0, 0, 0, 8'h00, 0, 3, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus("rst_rd01",   1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus("rst_rd23",   1, 0, 0, 8'h00, 0, 2, 3, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);

    applyStimulus("wr2_r0",     1, 1, 0, 8'h11, 0, 0, 0, R0_11, R0_11, 8'h00, 8'h00, 0, 0);
    applyStimulus("wr2_r1",     1, 1, 1, 8'h22, 0, 0, 1, R0_11, 8'h22, R0_11, 8'h00, 0, 0);
    applyStimulus("wr2_r2",     1, 1, 2, 8'h33, 0, 1, 2, 8'h22, 8'h33, 8'h22, 8'h00, 0, 0);
    applyStimulus("wr2_r3",     1, 1, 3, 8'h44, 0, 2, 3, 8'h33, 8'h44, 8'h33, 8'h00, 0, 0);
    applyStimulus("rd_23",      1, 0, 0, 8'h00, 0, 2, 3, 8'h33, 8'h44, 8'h33, 8'h44, 0, 0);
    applyStimulus("rd_11",      1, 0, 0, 8'h00, 0, 1, 1, 8'h22, 8'h22, 8'h22, 8'h22, 0, 0);
    applyStimulus("bypass",     1, 1, 1, 8'hA5, 0, 1, 0, 8'hA5, R0_11, 8'h22, R0_11, 0, 0);
    applyStimulus("after_byp",  1, 0, 0, 8'h00, 0, 1, 0, 8'hA5, R0_11, 8'hA5, R0_11, 0, 0);

    applyStimulus("clr_req",    1, 0, 0, 8'h00, 1, 3, 3, 8'h44, 8'h44, 8'h44, 8'h44, 0, 0);
    applyStimulus("clr1",       1, 1, 3, 8'hFF, 0, 3, 0, 8'h44, R0_11, 8'h44, R0_11, 1, 0);
    applyStimulus("clr2",       1, 1, 3, 8'hFF, 0, 0, 1, 8'h00, 8'hA5, 8'h00, 8'hA5, 1, 0);
    applyStimulus("clr3",       1, 1, 3, 8'hFF, 0, 1, 2, 8'h00, 8'h33, 8'h00, 8'h33, 1, 0);
    applyStimulus("clr4",       1, 0, 0, 8'h00, 0, 2, 3, 8'h00, 8'h44, 8'h00, 8'h44, 1, 0);
    applyStimulus("clr_done",   1, 0, 0, 8'h00, 0, 3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
    applyStimulus("post01",     1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus("post23",     1, 0, 0, 8'h00, 0, 2, 3, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);

    applyStimulus("wr_r2_77",   1, 1, 2, 8'h77, 0, 2, 0, 8'h77, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus("clr_req2",   1, 0, 0, 8'h00, 1, 2, 2, 8'h77, 8'h77, 8'h77, 8'h77, 0, 0);
    applyStimulus("abort1",     1, 0, 0, 8'h00, 0, 2, 2, 8'h77, 8'h77, 8'h77, 8'h77, 1, 0);
    applyStimulus("abort_rst",  0, 0, 0, 8'h00, 0, 2, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus("abort_rel",  1, 0, 0, 8'h00, 0, 2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus("no_done_a",  1, 0, 0, 8'h00, 0, 2, 3, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus("no_done_b",  1, 0, 0, 8'h00, 0, 1, 3, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);

    applyStimulus("wr_clr_idle",1, 1, 1, 8'h5C, 1, 1, 2, 8'h5C, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus("wc_clr1",    1, 0, 0, 8'h00, 0, 1, 2, 8'h5C, 8'h00, 8'h5C, 8'h00, 1, 0);
    applyStimulus("wc_clr2",    1, 0, 0, 8'h00, 0, 1, 2, 8'h5C, 8'h00, 8'h5C, 8'h00, 1, 0);
    applyStimulus("wc_clr3",    1, 0, 0, 8'h00, 0, 1, 2, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
    applyStimulus("wc_clr4",    1, 0, 0, 8'h00, 0, 1, 2, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
    applyStimulus("wc_done_wr", 1, 1, 2, 8'h66, 1, 2, 1, 8'h66, 8'h00, 8'h00, 8'h00, 0, 1);
    applyStimulus("rc_clr1",    1, 0, 0, 8'h00, 0, 2, 1, 8'h66, 8'h00, 8'h66, 8'h00, 1, 0);
    applyStimulus("rc_clr2",    1, 0, 0, 8'h00, 0, 2, 1, 8'h66, 8'h00, 8'h66, 8'h00, 1, 0);
    applyStimulus("rc_clr3",    1, 0, 0, 8'h00, 0, 2, 1, 8'h66, 8'h00, 8'h66, 8'h00, 1, 0);
    applyStimulus("rc_clr4",    1, 0, 0, 8'h00, 0, 2, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
    applyStimulus("rc_done",    1, 0, 0, 8'h00, 0, 2, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
    applyStimulus("rc_idle",    1, 0, 0, 8'h00, 0, 2, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);

    applyStimulus("r0_wr",      1, 1, 0, 8'h5A, 0, 0, 0, R0_5A, R0_5A, 8'h00, 8'h00, 0, 0);
    applyStimulus("r1_wr",      1, 1, 1, 8'h5A, 0, 0, 1, R0_5A, 8'h5A, R0_5A, 8'h00, 0, 0);
    applyStimulus("r01_rd",     1, 0, 0, 8'h00, 0, 0, 1, R0_5A, 8'h5A, R0_5A, 8'h5A, 0, 0);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL queue_drained: got %0d pending expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
